// File: rtl/tour_pkg.sv
// Shared types and constants for the knight-tour command sequencer.
// Includes the helpers that pack a leg command.
package tour_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEG1  = 3'd1,
        HOLD1 = 3'd2,
        LEG2  = 3'd3,
        HOLD2 = 3'd4
    } state_t;

    localparam logic [3:0] VERT_OP    = 4'b0011;
    localparam logic [3:0] HORI_OP    = 4'b0010;
    localparam logic [7:0] HEAD_UP    = 8'h00;
    localparam logic [7:0] HEAD_DOWN  = 8'h7F;
    localparam logic [7:0] HEAD_RIGHT = 8'hBF;
    localparam logic [7:0] HEAD_LEFT  = 8'h3F;
    localparam logic [3:0] SQ_ONE     = 4'h1;
    localparam logic [3:0] SQ_TWO     = 4'h2;
    localparam logic [7:0] RESP_DONE  = 8'hA5;
    localparam logic [7:0] RESP_BUSY  = 8'h5A;

    function automatic logic [15:0] vert_cmd(input logic up, input logic two);
        return {VERT_OP, (up ? HEAD_UP : HEAD_DOWN), (two ? SQ_TWO : SQ_ONE)};
    endfunction

    function automatic logic [15:0] hori_cmd(input logic right, input logic two);
        return {HORI_OP, (right ? HEAD_RIGHT : HEAD_LEFT), (two ? SQ_TWO : SQ_ONE)};
    endfunction

endpackage

// File: rtl/move_decode.sv
// Decodes a one-hot knight move into leg directions and lengths.
// valid is low for zero or multi-hot move codes.
module move_decode (
    input  logic [7:0] move_i,
    output logic       vert_up_o,
    output logic       vert_two_o,
    output logic       hori_right_o,
    output logic       hori_two_o,
    output logic       valid_o
);

    // Bit k of move selects knight jump k; group the jumps by leg property.
    always_comb begin
        vert_up_o    = |(move_i & 8'b1000_0111);
        vert_two_o   = |(move_i & 8'b0011_0011);
        hori_right_o = |(move_i & 8'b1110_0010);
        hori_two_o   = |(move_i & 8'b1100_1100);
        valid_o      = (move_i != 8'h00) && ((move_i & (move_i - 8'h01)) == 8'h00);
    end

endmodule

// File: rtl/tour_cmd_seq.sv
// Sequences a precomputed knight tour into two-leg motion commands.
// Outside a tour, the UART command path passes straight through to cmd_proc.
module tour_cmd_seq
    import tour_pkg::*;
#(
    parameter int         NUM_MOVES = 24,
    parameter int         IDX_W     = $clog2(NUM_MOVES),
    parameter logic [3:0] ABORT_OP  = 4'hF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_tour,
    input  logic             vert_first,
    input  logic [7:0]       move,
    output logic [IDX_W-1:0] mv_indx,
    input  logic [15:0]      cmd_UART,
    input  logic             cmd_rdy_UART,
    input  logic             clr_cmd_rdy,
    input  logic             send_resp,
    output logic [15:0]      cmd,
    output logic             cmd_rdy,
    output logic [7:0]       resp,
    output logic             clr_uart_rdy,
    output logic             busy,
    output logic             mv_err
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MOVES - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] mv_indx_q, mv_indx_d;
    logic             mode_q, mode_d;
    logic             mv_err_q, mv_err_d;
    logic             leg1_new_q, leg1_new_d;

    logic        vert_up_s, vert_two_s, hori_right_s, hori_two_s, mv_valid_s;
    logic [15:0] vert_cmd_s, hori_cmd_s, leg1_cmd_s, leg2_cmd_s;
    logic        abort_s, last_s;

    move_decode u_move_decode (
        .move_i       (move),
        .vert_up_o    (vert_up_s),
        .vert_two_o   (vert_two_s),
        .hori_right_o (hori_right_s),
        .hori_two_o   (hori_two_s),
        .valid_o      (mv_valid_s)
    );

    // Leg commands for the current move, ordered by the latched mode.
    always_comb begin
        vert_cmd_s = vert_cmd(vert_up_s, vert_two_s);
        hori_cmd_s = hori_cmd(hori_right_s, hori_two_s);
        leg1_cmd_s = mode_q ? vert_cmd_s : hori_cmd_s;
        leg2_cmd_s = mode_q ? hori_cmd_s : vert_cmd_s;
        abort_s    = cmd_rdy_UART && (cmd_UART[15:12] == ABORT_OP);
        last_s     = (mv_indx_q == LAST_IDX);
    end

    // Next-state and output decode; abort outranks every other tour event.
    always_comb begin
        state_d      = state_q;
        mv_indx_d    = mv_indx_q;
        mode_d       = mode_q;
        mv_err_d     = mv_err_q;
        leg1_new_d   = 1'b0;
        cmd          = cmd_UART;
        cmd_rdy      = 1'b0;
        resp         = RESP_BUSY;
        clr_uart_rdy = 1'b0;
        busy         = 1'b1;
        case (state_q)
            IDLE: begin
                cmd_rdy = cmd_rdy_UART;
                resp    = RESP_DONE;
                busy    = 1'b0;
                if (start_tour) begin
                    mv_indx_d  = '0;
                    mv_err_d   = 1'b0;
                    mode_d     = vert_first;
                    leg1_new_d = 1'b1;
                    state_d    = LEG1;
                end else begin
                    state_d = IDLE;
                end
            end
            LEG1: begin
                cmd = leg1_cmd_s;
                if (abort_s) begin
                    clr_uart_rdy = 1'b1;
                    state_d      = IDLE;
                end else if (leg1_new_q && !mv_valid_s) begin
                    mv_err_d = 1'b1;
                    state_d  = IDLE;
                end else begin
                    cmd_rdy = 1'b1;
                    state_d = clr_cmd_rdy ? HOLD1 : LEG1;
                end
            end
            HOLD1: begin
                cmd = leg2_cmd_s;
                if (abort_s) begin
                    clr_uart_rdy = 1'b1;
                    state_d      = IDLE;
                end else begin
                    state_d = send_resp ? LEG2 : HOLD1;
                end
            end
            LEG2: begin
                cmd = leg2_cmd_s;
                if (abort_s) begin
                    clr_uart_rdy = 1'b1;
                    state_d      = IDLE;
                end else begin
                    cmd_rdy = 1'b1;
                    state_d = clr_cmd_rdy ? HOLD2 : LEG2;
                end
            end
            HOLD2: begin
                // Next leg is leg 1 of the same index until send_resp advances it.
                cmd  = leg1_cmd_s;
                resp = last_s ? RESP_DONE : RESP_BUSY;
                if (abort_s) begin
                    clr_uart_rdy = 1'b1;
                    state_d      = IDLE;
                end else if (send_resp && last_s) begin
                    state_d = IDLE;
                end else if (send_resp) begin
                    mv_indx_d  = mv_indx_q + IDX_W'(1);
                    leg1_new_d = 1'b1;
                    state_d    = LEG1;
                end else begin
                    state_d = HOLD2;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Tour state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            mv_indx_q  <= '0;
            mode_q     <= 1'b0;
            mv_err_q   <= 1'b0;
            leg1_new_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mv_indx_q  <= mv_indx_d;
            mode_q     <= mode_d;
            mv_err_q   <= mv_err_d;
            leg1_new_q <= leg1_new_d;
        end
    end

    assign mv_indx = mv_indx_q;
    assign mv_err  = mv_err_q;

endmodule

// File: tb/tb_tour_cmd_seq.sv
// Bench for tour_cmd_seq: randomized tours against a knight-move reference model.
module tb_tour_cmd_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_tour, vert_first, clr_cmd_rdy, send_resp, cmd_rdy_UART;
    logic [15:0] cmd_UART;
    logic [7:0]  move;
    logic [4:0]  mv_indx;
    logic [15:0] cmd;
    logic        cmd_rdy, clr_uart_rdy, busy, mv_err;
    logic [7:0]  resp;

    logic        start4, clr4, send4;
    logic [7:0]  move4;
    logic [1:0]  mv_indx4;
    logic [15:0] cmd4;
    logic        cmd_rdy4, clr_uart_rdy4, busy4, mv_err4;
    logic [7:0]  resp4;

    logic [7:0] move_tbl  [0:23];
    logic [7:0] move_tbl4 [0:3];

    int n_cmp = 0;
    int n_err = 0;

    int dx_tbl [8] = '{-1, 1, -2, -2, -1, 1, 2, 2};
    int dy_tbl [8] = '{ 2, 2,  1, -1, -2, -2, -1, 1};

    always #5 clk = ~clk;

    assign move  = move_tbl[mv_indx];
    assign move4 = move_tbl4[mv_indx4];

    tour_cmd_seq dut (
        .clk(clk), .rst_n(rst_n), .start_tour(start_tour), .vert_first(vert_first),
        .move(move), .mv_indx(mv_indx), .cmd_UART(cmd_UART), .cmd_rdy_UART(cmd_rdy_UART),
        .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp), .cmd(cmd), .cmd_rdy(cmd_rdy),
        .resp(resp), .clr_uart_rdy(clr_uart_rdy), .busy(busy), .mv_err(mv_err)
    );

    tour_cmd_seq #(.NUM_MOVES(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start_tour(start4), .vert_first(1'b1),
        .move(move4), .mv_indx(mv_indx4), .cmd_UART(16'h0000), .cmd_rdy_UART(1'b0),
        .clr_cmd_rdy(clr4), .send_resp(send4), .cmd(cmd4), .cmd_rdy(cmd_rdy4),
        .resp(resp4), .clr_uart_rdy(clr_uart_rdy4), .busy(busy4), .mv_err(mv_err4)
    );

    // Command for one leg of a one-hot knight move, built from its (dx,dy) jump.
    function automatic logic [15:0] ref_cmd(input logic [7:0] mv, input bit vertical);
        int k;
        int d;
        logic [7:0] head;
        logic [3:0] sq;
        k = 0;
        for (int b = 0; b < 8; b++) if (mv[b]) k = b;
        if (vertical) begin
            d = dy_tbl[k];
            head = (d > 0) ? 8'h00 : 8'h7F;
        end else begin
            d = dx_tbl[k];
            head = (d > 0) ? 8'hBF : 8'h3F;
        end
        sq = 4'((d < 0) ? -d : d);
        return {(vertical ? 4'h3 : 4'h2), head, sq};
    endfunction

    task automatic pulse_clr();
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
    endtask

    task automatic pulse_send();
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
    endtask

    task automatic fill_random();
        for (int i = 0; i < 24; i++) move_tbl[i] = 8'h01 << $urandom_range(0, 7);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start_tour = 1'b0; vert_first = 1'b0; clr_cmd_rdy = 1'b0; send_resp = 1'b0;
        cmd_rdy_UART = 1'b0; cmd_UART = 16'h0000;
        start4 = 1'b0; clr4 = 1'b0; send4 = 1'b0;
        fill_random();
        for (int i = 0; i < 4; i++) move_tbl4[i] = 8'h01 << $urandom_range(0, 7);
        @(negedge clk);
        #1;
        n_cmp++;
        if ({mv_indx, resp, busy, mv_err, clr_uart_rdy, cmd_rdy} !== {5'd0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_state got=%h exp=%h", {mv_indx, resp, busy, mv_err, clr_uart_rdy, cmd_rdy},
                     {5'd0, 8'hA5, 4'b0000});
        end
        @(negedge clk);
        rst_n = 1'b1;
        cmd_UART = 16'h1234; cmd_rdy_UART = 1'b1;
        #1;
        n_cmp++;
        if ({cmd, cmd_rdy, clr_uart_rdy} !== {16'h1234, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL idle_passthru got=%h exp=%h", {cmd, cmd_rdy, clr_uart_rdy}, {16'h1234, 2'b10});
        end
        cmd_rdy_UART = 1'b0;
    endtask

    // Full tour with random handshake delays; fixed_mv of zero means random moves.
    task automatic test_full_tour(input bit vf, input logic [7:0] fixed_mv);
        logic [15:0] exp_c;
        logic [7:0]  exp_r;
        if (fixed_mv == 8'h00) fill_random();
        else for (int i = 0; i < 24; i++) move_tbl[i] = fixed_mv;
        cmd_UART = {4'($urandom_range(0, 14)), 12'($urandom)};
        cmd_rdy_UART = 1'b1;
        @(negedge clk);
        start_tour = 1'b1; vert_first = vf;
        @(negedge clk);
        start_tour = 1'b0;
        for (int i = 0; i < 24; i++) begin
            for (int l = 0; l < 2; l++) begin
                #1;
                exp_c = ref_cmd(move_tbl[i], (l == 0) ? vf : !vf);
                n_cmp++;
                if ({cmd_rdy, cmd, resp, busy, clr_uart_rdy, mv_err, mv_indx} !==
                    {1'b1, exp_c, 8'h5A, 1'b1, 1'b0, 1'b0, 5'(i)}) begin
                    n_err++;
                    $display("FAIL tour_leg i=%0d l=%0d got cmd=%h rdy=%b resp=%h idx=%0d exp cmd=%h",
                             i, l, cmd, cmd_rdy, resp, mv_indx, exp_c);
                end
                repeat ($urandom_range(0, 2)) @(negedge clk);
                pulse_clr();
                #1;
                exp_c = ref_cmd(move_tbl[i], (l == 0) ? !vf : vf);
                exp_r = (l == 1 && i == 23) ? 8'hA5 : 8'h5A;
                n_cmp++;
                if ({cmd_rdy, cmd, resp, busy, clr_uart_rdy} !== {1'b0, exp_c, exp_r, 1'b1, 1'b0}) begin
                    n_err++;
                    $display("FAIL tour_hold i=%0d l=%0d got cmd=%h rdy=%b resp=%h exp cmd=%h resp=%h",
                             i, l, cmd, cmd_rdy, resp, exp_c, exp_r);
                end
                repeat ($urandom_range(0, 2)) @(negedge clk);
                pulse_send();
            end
        end
        #1;
        n_cmp++;
        if ({busy, resp, mv_indx, cmd, cmd_rdy} !== {1'b0, 8'hA5, 5'd23, cmd_UART, 1'b1}) begin
            n_err++;
            $display("FAIL tour_end got busy=%b resp=%h idx=%0d cmd=%h rdy=%b exp busy=0 resp=a5 idx=23 cmd=%h",
                     busy, resp, mv_indx, cmd, cmd_rdy, cmd_UART);
        end
        cmd_rdy_UART = 1'b0;
    endtask

    task automatic test_abort();
        fill_random();
        @(negedge clk);
        start_tour = 1'b1; vert_first = 1'b0;
        @(negedge clk);
        start_tour = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pulse_clr(); pulse_send(); pulse_clr(); pulse_send();
        end
        pulse_clr();
        cmd_UART = 16'hF000; cmd_rdy_UART = 1'b1; send_resp = 1'b1;
        #1;
        n_cmp++;
        if ({clr_uart_rdy, busy, mv_indx} !== {1'b1, 1'b1, 5'd5}) begin
            n_err++;
            $display("FAIL abort_pulse got clr=%b busy=%b idx=%0d exp clr=1 busy=1 idx=5", clr_uart_rdy, busy, mv_indx);
        end
        @(negedge clk);
        send_resp = 1'b0;
        #1;
        n_cmp++;
        if ({clr_uart_rdy, busy, cmd_rdy, cmd, resp} !== {1'b0, 1'b0, 1'b1, 16'hF000, 8'hA5}) begin
            n_err++;
            $display("FAIL abort_idle got clr=%b busy=%b rdy=%b cmd=%h resp=%h", clr_uart_rdy, busy, cmd_rdy, cmd, resp);
        end
        cmd_rdy_UART = 1'b0;
        // Abort must also win over clr_cmd_rdy in a leg state.
        @(negedge clk);
        start_tour = 1'b1;
        @(negedge clk);
        start_tour = 1'b0;
        cmd_UART = 16'hF0AB; cmd_rdy_UART = 1'b1; clr_cmd_rdy = 1'b1;
        @(negedge clk);
        cmd_rdy_UART = 1'b0; clr_cmd_rdy = 1'b0;
        #1;
        n_cmp++;
        if ({busy, clr_uart_rdy, resp} !== {1'b0, 1'b0, 8'hA5}) begin
            n_err++;
            $display("FAIL abort_leg1 got busy=%b clr=%b resp=%h exp busy=0 clr=0 resp=a5", busy, clr_uart_rdy, resp);
        end
    endtask

    task automatic test_move_err();
        fill_random();
        move_tbl[2] = 8'h03;
        @(negedge clk);
        start_tour = 1'b1; vert_first = 1'($urandom_range(0, 1));
        @(negedge clk);
        start_tour = 1'b0;
        for (int i = 0; i < 2; i++) begin
            pulse_clr(); pulse_send(); pulse_clr(); pulse_send();
        end
        #1;
        n_cmp++;
        if ({cmd_rdy, mv_indx} !== {1'b0, 5'd2}) begin
            n_err++;
            $display("FAIL err_no_rdy got rdy=%b idx=%0d exp rdy=0 idx=2", cmd_rdy, mv_indx);
        end
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if ({busy, mv_err, resp} !== {1'b0, 1'b1, 8'hA5}) begin
            n_err++;
            $display("FAIL err_sticky got busy=%b err=%b resp=%h exp busy=0 err=1 resp=a5", busy, mv_err, resp);
        end
        move_tbl[0] = 8'h00;
        @(negedge clk);
        start_tour = 1'b1;
        @(negedge clk);
        start_tour = 1'b0;
        #1;
        n_cmp++;
        if ({mv_err, cmd_rdy, busy} !== {1'b0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL err_clear got err=%b rdy=%b busy=%b exp err=0 rdy=0 busy=1", mv_err, cmd_rdy, busy);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if ({mv_err, busy} !== {1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL err_zero got err=%b busy=%b exp err=1 busy=0", mv_err, busy);
        end
    endtask

    task automatic test_reset_mid();
        fill_random();
        @(negedge clk);
        start_tour = 1'b1; vert_first = 1'b1;
        @(negedge clk);
        start_tour = 1'b0;
        pulse_clr(); pulse_send(); pulse_clr(); pulse_send();
        pulse_clr(); pulse_send();
        #1;
        n_cmp++;
        if ({cmd_rdy, mv_indx, cmd} !== {1'b1, 5'd1, ref_cmd(move_tbl[1], 1'b0)}) begin
            n_err++;
            $display("FAIL mid_leg2 got rdy=%b idx=%0d cmd=%h", cmd_rdy, mv_indx, cmd);
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({mv_indx, resp, busy, cmd_rdy, mv_err} !== {5'd0, 8'hA5, 1'b0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL async_reset got idx=%0d resp=%h busy=%b rdy=%b", mv_indx, resp, busy, cmd_rdy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            n_cmp++;
            if ({cmd_rdy, busy} !== 2'b00) begin
                n_err++;
                $display("FAIL reset_abandon cyc=%0d got rdy=%b busy=%b exp 0 0", i, cmd_rdy, busy);
            end
        end
    endtask

    task automatic test_short_tour();
        logic [15:0] exp_c;
        @(negedge clk);
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            for (int l = 0; l < 2; l++) begin
                #1;
                exp_c = ref_cmd(move_tbl4[i], l == 0);
                n_cmp++;
                if ({cmd_rdy4, cmd4, mv_indx4, busy4} !== {1'b1, exp_c, 2'(i), 1'b1}) begin
                    n_err++;
                    $display("FAIL short_leg i=%0d l=%0d got rdy=%b cmd=%h idx=%0d exp cmd=%h",
                             i, l, cmd_rdy4, cmd4, mv_indx4, exp_c);
                end
                clr4 = 1'b1;
                @(negedge clk);
                clr4 = 1'b0;
                send4 = 1'b1;
                @(negedge clk);
                send4 = 1'b0;
            end
        end
        #1;
        n_cmp++;
        if ({busy4, mv_indx4, resp4, clr_uart_rdy4, mv_err4} !== {1'b0, 2'd3, 8'hA5, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL short_end got busy=%b idx=%0d resp=%h exp busy=0 idx=3 resp=a5", busy4, mv_indx4, resp4);
        end
    endtask

    initial begin
        test_reset();
        test_full_tour(1'b0, 8'h02);
        test_full_tour(1'b1, 8'h08);
        test_full_tour(1'($urandom_range(0, 1)), 8'h00);
        test_abort();
        test_move_err();
        test_reset_mid();
        test_short_tour();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tour_cmd_seq.md
TOUR_CMD_SEQ -- requirements
Module: tour_cmd_seq

Interface
REQ-001 SHALL have parameter NUM_MOVES, default 24, number of moves per tour (2..256).
REQ-002 SHALL have parameter IDX_W, default $clog2(NUM_MOVES), width of mv_indx.
REQ-003 SHALL have parameter ABORT_OP, default 4'hF, UART opcode (cmd_UART[15:12]) that aborts a tour.
REQ-004 SHALL have ports: clk  in  1  system clock; rst_n  in  1  reset.
REQ-005 SHALL have ports: start_tour  in  1  tour solution ready; vert_first  in  1  leg order for the tour; move  in  8  one-hot move at mv_indx; mv_indx  out  IDX_W  move address.
REQ-006 SHALL have ports: cmd_UART  in  16; cmd_rdy_UART  in  1; clr_cmd_rdy  in  1  from cmd_proc; send_resp  in  1  cmd_proc done; cmd  out  16; cmd_rdy  out  1; resp  out  8; clr_uart_rdy  out  1  consume UART cmd; busy  out  1; mv_err  out  1.
REQ-007 SHALL use one clock, clk; reset rst_n SHALL be asynchronous and active-low.

Function
REQ-008 SHALL implement states IDLE, LEG1, HOLD1, LEG2, HOLD2.
REQ-009 IDLE: cmd=cmd_UART, cmd_rdy=cmd_rdy_UART, resp=8'hA5, busy=0; all other states: busy=1, cmd from tour logic, resp=8'h5A unless REQ-015.
REQ-010 IDLE with start_tour=1: clear mv_indx, clear mv_err, latch vert_first into a mode flop, go LEG1 next cycle; start_tour outside IDLE SHALL be ignored.
REQ-011 LEG1/LEG2: cmd_rdy=1; clr_cmd_rdy moves LEG1->HOLD1, LEG2->HOLD2 next cycle.
REQ-012 HOLD1/HOLD2: cmd_rdy=0; cmd SHALL already present the following leg's command (HOLD1 shows leg-2 cmd, HOLD2 shows leg-1 cmd of current index).
REQ-013 HOLD1 with send_resp -> LEG2.
REQ-014 HOLD2 with send_resp: if mv_indx==NUM_MOVES-1 -> IDLE, else increment mv_indx and -> LEG1 in same cycle.
REQ-015 HOLD2 with mv_indx==NUM_MOVES-1: resp=8'hA5.
REQ-016 Leg order: mode=0 horizontal leg first, vertical second; mode=1 vertical first.
REQ-017 Vertical cmd: {4'b0011, heading, squares}; heading 8'h00 up, 8'h7F down. Horizontal cmd: {4'b0010, heading, squares}; heading 8'hBF right, 8'h3F left; squares 4'h1 or 4'h2.
REQ-018 Move decode (bit: dx,dy): 0:-1,+2; 1:+1,+2; 2:-2,+1; 3:-2,-1; 4:-1,-2; 5:+1,-2; 6:+2,-1; 7:+2,+1.
REQ-019 Move not one-hot when entering LEG1 (checked in cycle state==LEG1 first occurs for that index): set mv_err=1 (sticky until next accepted start_tour), cmd_rdy=0, go IDLE next cycle.
REQ-020 Abort: in any non-IDLE state, cmd_rdy_UART=1 with cmd_UART[15:12]==ABORT_OP SHALL pulse clr_uart_rdy for one cycle and go IDLE next cycle; abort has priority over clr_cmd_rdy, send_resp and move error.
REQ-021 Non-abort UART cmds during a tour SHALL not be consumed or forwarded; they remain pending for IDLE.
REQ-022 clr_uart_rdy SHALL be 0 except REQ-020.
REQ-023 mv_indx SHALL never exceed NUM_MOVES-1; no wrap.

Reset
REQ-024 rst_n low: state=IDLE, mv_indx=0, mode=0, mv_err=0 asynchronously; outputs then follow IDLE rules (resp=8'hA5, busy=0, clr_uart_rdy=0).
REQ-025 Reset mid-tour SHALL abandon the tour with no further tour cmd_rdy.

Structure
REQ-026 Package tour_pkg SHALL hold state_t, opcodes (VERT_OP, HORI_OP), heading constants, RESP_DONE=8'hA5, RESP_BUSY=8'h5A.
REQ-027 Sub-module move_decode SHALL map move to {vert_up, vert_two, hori_right, hori_two, valid}.

Verification
REQ-028 NUM_MOVES=24, mode=0, all moves 8'h02: 24 pairs cmd 16'h2BF1 then 16'h3002; resp 5A until last HOLD2, then A5; IDLE after 48 handshakes.
REQ-029 mode=1, move 8'h08: first cmd 16'h37F1, then 16'h23F2.
REQ-030 NUM_MOVES=4: mv_indx 0..3, returns IDLE after 8th send_resp, mv_indx holds 3.
REQ-031 Abort cmd 16'hF000 with cmd_rdy_UART during HOLD1 at index 5: clr_uart_rdy one-cycle pulse, IDLE next cycle, busy=0.
REQ-032 move=8'h03 at index 2: mv_err=1, no cmd_rdy, IDLE; next start_tour clears mv_err.
REQ-033 rst_n low in LEG2: state IDLE, mv_indx 0, resp A5 immediately, before next clk edge.
